// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: active-low glyph table for hex digits and the blank pattern.
package sevenseg_pkg;

    typedef logic [6:0] seg_t;  // {g,f,e,d,c,b,a}, active-low

    localparam seg_t SEG_OFF = 7'h7F;

    localparam seg_t HEX_SEG_N [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/sevenseg_hex_n.sv
// Combinational nibble to active-low segment pattern lookup.
module sevenseg_hex_n (
    input  logic [3:0] nib_i,
    output logic [6:0] segs_n_o
);
    import sevenseg_pkg::*;

    seg_t seg_lookup;

    always_comb begin
        seg_lookup = HEX_SEG_N[nib_i];
    end

    assign segs_n_o = seg_lookup;

endmodule

// File: rtl/sevenseg_scan_ctl.sv
// Multiplexed common-anode seven-segment scanner with frame-coherent snapshots,
// leading-zero suppression, per-digit blink, brightness duty and a ghosting guard.
module sevenseg_scan_ctl #(
    parameter int NDIG         = 8,
    parameter int SLOT_CYCLES  = 12500,
    parameter int GUARD        = 4,
    parameter int BRT_W        = 3,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*NDIG-1:0]   hex_in,
    input  logic [NDIG-1:0]     dp_in,
    input  logic [NDIG-1:0]     blink_in,
    input  logic                lz_sup,
    input  logic [BRT_W-1:0]    brt,
    output logic [NDIG-1:0]     an_n,
    output logic [6:0]          segs_n,
    output logic                dp_n
);
    import sevenseg_pkg::*;

    localparam int SCW = $clog2(SLOT_CYCLES + 1);
    localparam int DW  = $clog2(NDIG);
    localparam int FCW = $clog2(BLINK_FRAMES + 1);
    localparam int PW  = SCW + BRT_W + 1;

    logic [SCW-1:0]    slot_cnt_q, slot_cnt_d;
    logic [DW-1:0]     dig_q, dig_d;
    logic [FCW-1:0]    frame_cnt_q, frame_cnt_d;
    logic              blink_ph_q, blink_ph_d;
    logic              init_q, init_d;
    logic [SCW-1:0]    thr_q, thr_d;

    logic [4*NDIG-1:0] hex_snap_q, hex_snap_d;
    logic [NDIG-1:0]   dp_snap_q, dp_snap_d;
    logic [NDIG-1:0]   blink_snap_q, blink_snap_d;
    logic              lz_snap_q, lz_snap_d;

    logic [NDIG-1:0]   an_n_q, an_n_d;
    seg_t              segs_n_q, segs_n_d;
    logic              dp_n_q, dp_n_d;

    logic              slot_wrap;
    logic              frame_wrap;
    logic              snap_load;
    logic              slot_load;
    logic [PW-1:0]     thr_prod;
    logic [NDIG-1:0]   supp;
    logic              lead;
    logic [3:0]        cur_nib;
    seg_t              cur_segs_n;
    logic              in_win;
    logic              lit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt_q   <= '0;
            dig_q        <= '0;
            frame_cnt_q  <= '0;
            blink_ph_q   <= 1'b0;
            init_q       <= 1'b1;
            thr_q        <= SCW'(GUARD);
            hex_snap_q   <= '0;
            dp_snap_q    <= '0;
            blink_snap_q <= '0;
            lz_snap_q    <= 1'b0;
            an_n_q       <= '1;
            segs_n_q     <= SEG_OFF;
            dp_n_q       <= 1'b1;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            dig_q        <= dig_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_ph_q   <= blink_ph_d;
            init_q       <= init_d;
            thr_q        <= thr_d;
            hex_snap_q   <= hex_snap_d;
            dp_snap_q    <= dp_snap_d;
            blink_snap_q <= blink_snap_d;
            lz_snap_q    <= lz_snap_d;
            an_n_q       <= an_n_d;
            segs_n_q     <= segs_n_d;
            dp_n_q       <= dp_n_d;
        end
    end

    // Scan and blink timebase.
    always_comb begin
        slot_wrap   = (slot_cnt_q == SCW'(SLOT_CYCLES - 1));
        frame_wrap  = slot_wrap && (dig_q == DW'(NDIG - 1));
        slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + SCW'(1);
        dig_d       = dig_q;
        frame_cnt_d = frame_cnt_q;
        blink_ph_d  = blink_ph_q;
        init_d      = 1'b0;
        if (slot_wrap) begin
            dig_d = (dig_q == DW'(NDIG - 1)) ? '0 : dig_q + DW'(1);
        end
        if (frame_wrap) begin
            if (frame_cnt_q == FCW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FCW'(1);
            end
        end
    end

    // init_q makes the first cycle after reset behave as a frame/slot start, so the
    // loaded snapshot and threshold are already in place when slot_cnt reaches 1.
    always_comb begin
        snap_load    = init_q || frame_wrap;
        slot_load    = init_q || slot_wrap;
        hex_snap_d   = snap_load ? hex_in   : hex_snap_q;
        dp_snap_d    = snap_load ? dp_in    : dp_snap_q;
        blink_snap_d = snap_load ? blink_in : blink_snap_q;
        lz_snap_d    = snap_load ? lz_sup   : lz_snap_q;
        thr_prod     = PW'(SLOT_CYCLES - GUARD) * (PW'(brt) + PW'(1));
        thr_d        = slot_load ? (SCW'(GUARD) + SCW'(thr_prod >> BRT_W)) : thr_q;
    end

    // Walk from the most significant digit; suppression stops at the first nonzero nibble or dp.
    always_comb begin
        supp = '0;
        lead = lz_snap_q;
        for (int k = NDIG - 1; k >= 1; k--) begin
            if ((hex_snap_q[4*k +: 4] != 4'h0) || dp_snap_q[k]) begin
                lead = 1'b0;
            end
            supp[k] = lead;
        end
    end

    always_comb begin
        cur_nib = hex_snap_q[4*int'(dig_q) +: 4];
    end

    sevenseg_hex_n u_hex (
        .nib_i    (cur_nib),
        .segs_n_o (cur_segs_n)
    );

    always_comb begin
        in_win   = (slot_cnt_q >= SCW'(GUARD)) && (slot_cnt_q < thr_q);
        lit      = in_win && !supp[dig_q] && !(blink_snap_q[dig_q] && blink_ph_q);
        an_n_d   = '1;
        segs_n_d = SEG_OFF;
        dp_n_d   = 1'b1;
        if (lit) begin
            for (int k = 0; k < NDIG; k++) begin
                if (dig_q == DW'(k)) begin
                    an_n_d[k] = 1'b0;
                end
            end
            segs_n_d = cur_segs_n;
            dp_n_d   = ~dp_snap_q[dig_q];
        end
    end

    assign an_n   = an_n_q;
    assign segs_n = segs_n_q;
    assign dp_n   = dp_n_q;

endmodule

// File: tb/tb_sevenseg_scan_ctl.sv
// Bench for sevenseg_scan_ctl: time-indexed reference model plus literal scenario checks.
module tb_sevenseg_scan_ctl;

    localparam int NDIG = 4;
    localparam int SLOT = 16;
    localparam int GRD  = 2;
    localparam int BW   = 2;
    localparam int BF   = 2;
    localparam int FRAME = SLOT * NDIG;
    localparam logic [11:0] DARK = {4'hF, 7'h7F, 1'b1};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [4*NDIG-1:0] hex_in = '0;
    logic [NDIG-1:0]   dp_in = '0;
    logic [NDIG-1:0]   blink_in = '0;
    logic              lz_sup = 1'b0;
    logic [BW-1:0]     brt = '1;
    logic [NDIG-1:0]   an_n;
    logic [6:0]        segs_n;
    logic              dp_n;

    sevenseg_scan_ctl #(
        .NDIG(NDIG), .SLOT_CYCLES(SLOT), .GUARD(GRD), .BRT_W(BW), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst(rst), .hex_in(hex_in), .dp_in(dp_in), .blink_in(blink_in),
        .lz_sup(lz_sup), .brt(brt), .an_n(an_n), .segs_n(segs_n), .dp_n(dp_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    logic [6:0] seg_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Model state: edges since reset release and the input values latched at frame/slot starts.
    int          n_edge = 0;
    logic [15:0] m_hex = '0;
    logic [3:0]  m_dp = '0;
    logic [3:0]  m_blink = '0;
    logic        m_lz = 1'b0;
    int          m_brt = 0;
    logic [11:0] exp_q[$];
    logic [11:0] last_exp = DARK;

    function automatic logic [11:0] model_out(int t, logic [15:0] h, logic [3:0] d,
                                              logic [3:0] b, logic lz, int br);
        int  slot = t % SLOT;
        int  dg   = (t / SLOT) % NDIG;
        int  ph   = ((t / FRAME) / BF) % 2;
        int  thr  = GRD + ((SLOT - GRD) * (br + 1)) / (1 << BW);
        bit  sup  = 1'b0;
        logic [3:0] onehot;
        if (lz && dg > 0) begin
            sup = 1'b1;
            for (int j = NDIG - 1; j >= dg; j--)
                if (h[4*j +: 4] != 4'h0 || d[j]) sup = 1'b0;
        end
        if (slot >= GRD && slot < thr && !sup && !(b[dg] && ph == 1)) begin
            onehot = 4'b0001 << dg;
            return {~onehot, seg_tab[h[4*dg +: 4]], ~d[dg]};
        end
        return DARK;
    endfunction

    task automatic check(string name, logic [11:0] act, logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got an_n=%b segs_n=%h dp_n=%b, expected an_n=%b segs_n=%h dp_n=%b",
                     name, $time, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            n_edge = 0;
            m_hex = '0; m_dp = '0; m_blink = '0; m_lz = 1'b0; m_brt = 0;
            exp_q.delete();
        end else begin
            exp_q.push_back(model_out(n_edge, m_hex, m_dp, m_blink, m_lz, m_brt));
            n_edge++;
            if (n_edge == 1 || n_edge % FRAME == 0) begin
                m_hex = hex_in; m_dp = dp_in; m_blink = blink_in; m_lz = lz_sup;
            end
            if (n_edge == 1 || n_edge % SLOT == 0) m_brt = int'(brt);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("reset_dark", {an_n, segs_n, dp_n}, DARK);
            last_exp = DARK;
        end else if (exp_q.size() > 0) begin
            last_exp = exp_q.pop_front();
            check("scan_model", {an_n, segs_n, dp_n}, last_exp);
        end
        checks++;
        assert ($countones(~an_n) <= 1)
        else begin
            fails++;
            $display("FAIL onehot_an @%0t: got an_n=%b, expected at most one low bit", $time, an_n);
        end
    end

    int         cap_cnt [NDIG];
    logic [6:0] cap_seg [NDIG];
    logic       cap_dp  [NDIG];

    task automatic align(int period, bit pre_wait);
        int waited = 0;
        if (pre_wait) @(negedge clk);
        while (n_edge % period != 0 && waited < 4 * FRAME) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 4 * FRAME) begin
            checks++; fails++;
            $display("FAIL align_timeout @%0t: got no boundary within %0d cycles, expected one", $time, waited);
        end
    endtask

    task automatic capture_frame(bit pre_wait, int inject_at);
        logic [3:0] oh;
        align(FRAME, pre_wait);
        for (int d = 0; d < NDIG; d++) begin
            cap_cnt[d] = 0; cap_seg[d] = 7'h7F; cap_dp[d] = 1'b1;
        end
        for (int i = 1; i <= FRAME; i++) begin
            @(negedge clk);
            #1;
            if (i == inject_at) hex_in = 16'h2222;
            for (int d = 0; d < NDIG; d++) begin
                oh = 4'b0001 << d;
                if (an_n == ~oh) begin
                    cap_cnt[d]++; cap_seg[d] = segs_n; cap_dp[d] = dp_n;
                end
            end
        end
    endtask

    task automatic count_slot(output int cnt);
        align(SLOT, 1'b1);
        cnt = 0;
        repeat (SLOT) begin
            @(negedge clk);
            #1;
            if (an_n != 4'hF) cnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            check("in_reset", {an_n, segs_n, dp_n}, DARK);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        int waited;
        logic [6:0] exp_seg [NDIG];
        hex_in = 16'h1234; brt = 2'd3; lz_sup = 1'b0; dp_in = '0; blink_in = '0;
        do_reset();

        // First lit cycle comes at the third edge after release.
        @(negedge clk); #1; check("post_rel_e1", {an_n, segs_n, dp_n}, DARK);
        @(negedge clk); #1; check("post_rel_e2", {an_n, segs_n, dp_n}, DARK);
        @(negedge clk); #1; check("first_lit", {an_n, segs_n, dp_n}, {4'b1110, 7'h19, 1'b1});

        capture_frame(1'b1, -1);
        exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
        for (int d = 0; d < NDIG; d++) begin
            check_int($sformatf("scan_cnt_d%0d", d), cap_cnt[d], 14);
            check_int($sformatf("scan_seg_d%0d", d), int'(cap_seg[d]), int'(exp_seg[d]));
        end

        brt = 2'd0; count_slot(cnt); check_int("brt0_lit", cnt, 3);
        brt = 2'd1; count_slot(cnt); check_int("brt1_lit", cnt, 7);
        brt = 2'd3;

        lz_sup = 1'b1; hex_in = 16'h0050;
        capture_frame(1'b1, -1);
        check_int("lz_d3_dark", cap_cnt[3], 0);
        check_int("lz_d2_dark", cap_cnt[2], 0);
        check_int("lz_d1_cnt", cap_cnt[1], 14);
        check_int("lz_d1_seg", int'(cap_seg[1]), 'h12);
        check_int("lz_d0_seg", int'(cap_seg[0]), 'h40);

        hex_in = 16'h0000;
        capture_frame(1'b1, -1);
        check_int("lz0_d0_cnt", cap_cnt[0], 14);
        check_int("lz0_others", cap_cnt[1] + cap_cnt[2] + cap_cnt[3], 0);

        dp_in = 4'b0100;
        capture_frame(1'b1, -1);
        check_int("lzdp_d3_dark", cap_cnt[3], 0);
        check_int("lzdp_d2_cnt", cap_cnt[2], 14);
        check_int("lzdp_d2_seg", int'(cap_seg[2]), 'h40);
        check_int("lzdp_d2_dp", int'(cap_dp[2]), 0);
        check_int("lzdp_d1_cnt", cap_cnt[1], 14);

        // Asynchronous reset while a digit is lit.
        hex_in = 16'h1234; dp_in = '0; lz_sup = 1'b0;
        waited = 0;
        do begin
            @(negedge clk); #1; waited++;
        end while (last_exp[11:8] == 4'hF && waited < 2 * SLOT);
        #1 rst = 1'b1;
        #1 check("async_rst_dark", {an_n, segs_n, dp_n}, DARK);

        blink_in = 4'b0001;
        do_reset();
        for (int f = 0; f < 5; f++) begin
            capture_frame(1'b0, -1);
            check_int($sformatf("blink_d0_f%0d", f), cap_cnt[0], (f == 2 || f == 3) ? 0 : 14);
            check_int($sformatf("blink_d1_f%0d", f), cap_cnt[1], 14);
        end

        blink_in = '0; hex_in = 16'h1111;
        capture_frame(1'b1, -1);
        capture_frame(1'b0, 20);
        for (int d = 0; d < NDIG; d++)
            check_int($sformatf("coh_old_d%0d", d), int'(cap_seg[d]), 'h79);
        capture_frame(1'b0, -1);
        for (int d = 0; d < NDIG; d++)
            check_int($sformatf("coh_new_d%0d", d), int'(cap_seg[d]), 'h24);

        repeat (12 * FRAME) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0) begin
                hex_in   = 16'($urandom);
                if ($urandom_range(0, 2) == 0) hex_in[15:8] = 8'h00;
                dp_in    = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
                blink_in = 4'($urandom_range(0, 15));
                lz_sup   = 1'($urandom_range(0, 1));
                brt      = 2'($urandom_range(0, 3));
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        fails++;
        $display("FAIL watchdog @%0t: got no completion, expected end of test", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
